// File: rtl/frame_seq_if.sv
// Bundle of frame memory data, sequencing controls and display outputs for frame_seq.
// master drives the controls and frame data; slave is the sequencer itself.
interface frame_seq_if #(
  parameter int unsigned FRAME_NUM = 6,
  parameter int unsigned DW        = 12,
  parameter int unsigned IW        = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1
);
  logic [FRAME_NUM*DW-1:0] dout;
  logic                    frame_start;
  logic [1:0]              mode;
  logic                    pause;
  logic                    step;
  logic                    restart;
  logic [DW-1:0]           rdata;
  logic [IW-1:0]           frame_idx;
  logic                    frame_tick;
  logic                    done;

  modport master (
    output dout, frame_start, mode, pause, step, restart,
    input  rdata, frame_idx, frame_tick, done
  );

  modport slave (
    input  dout, frame_start, mode, pause, step, restart,
    output rdata, frame_idx, frame_tick, done
  );
endinterface

// File: rtl/frame_seq.sv
// Frame buffer sequencer: advances the displayed frame on vertical blanking after a hold
// interval (or a manual step), in loop, ping-pong, one-shot or hold order.
module frame_seq #(
  parameter int unsigned FRAME_NUM   = 6,
  parameter int unsigned SWITCH_TIME = 20000000,
  parameter int unsigned DW          = 12,
  parameter int unsigned IW          = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1
) (
  input logic        pclk,
  input logic        rst,
  frame_seq_if.slave bus
);

  localparam int unsigned TW = $clog2(SWITCH_TIME);
  localparam logic [TW-1:0] TLast = TW'(SWITCH_TIME - 1);
  localparam logic [IW-1:0] ILast = IW'(FRAME_NUM - 1);

  localparam logic [1:0] ModeLoop    = 2'b00;
  localparam logic [1:0] ModePing    = 2'b01;
  localparam logic [1:0] ModeOneShot = 2'b10;
  localparam logic [1:0] ModeHold    = 2'b11;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] idx_q, idx_d;
  dir_e          dir_q, dir_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic run, expire, step_acc, hold, adv;

  always_comb begin
    hold     = (bus.mode == ModeHold);
    run      = !hold && !bus.pause;
    expire   = run && (timer_q == TLast);
    step_acc = bus.step && bus.pause;
    adv      = bus.frame_start && !hold && (pending_q || expire || step_acc);

    timer_d = timer_q;
    if (run) begin
      timer_d = expire ? '0 : timer_q + TW'(1);
    end

    pending_d = pending_q;
    if (hold || adv) begin
      pending_d = 1'b0;
    end else if (expire || step_acc) begin
      pending_d = 1'b1;
    end

    idx_d = idx_q;
    // Direction only matters in ping-pong; holding it at up elsewhere makes entry start upward.
    dir_d  = (bus.mode == ModePing) ? dir_q : DirUp;
    done_d = (bus.mode == ModeOneShot) ? done_q : 1'b0;

    if (adv && (FRAME_NUM > 1)) begin
      case (bus.mode)
        ModeLoop: begin
          idx_d = (idx_q == ILast) ? '0 : idx_q + IW'(1);
        end
        ModePing: begin
          if (dir_q == DirUp) begin
            if (idx_q == ILast) begin
              idx_d = idx_q - IW'(1);
              dir_d = DirDown;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            if (idx_q == '0) begin
              idx_d = IW'(1);
              dir_d = DirUp;
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
        end
        ModeOneShot: begin
          if (idx_q != ILast) begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end

    if (adv && (bus.mode == ModeOneShot) && (idx_d == ILast)) begin
      done_d = 1'b1;
    end

    tick_d = (idx_d != idx_q);

    if (bus.restart) begin
      timer_d   = '0;
      pending_d = 1'b0;
      idx_d     = '0;
      dir_d     = DirUp;
      done_d    = 1'b0;
      tick_d    = 1'b0;
    end

    rdata_d = '0;
    for (int k = 0; k < FRAME_NUM; k++) begin
      if (idx_q == IW'(k)) begin
        rdata_d = bus.dout[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      timer_q   <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      dir_q     <= DirUp;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.frame_idx  = idx_q;
  assign bus.frame_tick = tick_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_frame_seq.sv
// Directed self-checking bench for frame_seq with 6 frames, a 20-cycle hold interval and
// 12-bit pixels where frame k carries 12'h100*k+1.
module tb_frame_seq;

  localparam int unsigned FN = 6;
  localparam int unsigned ST = 20;
  localparam int unsigned DW = 12;
  localparam int unsigned IW = 3;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  frame_seq_if #(.FRAME_NUM(FN), .DW(DW), .IW(IW)) bus ();

  frame_seq #(
    .FRAME_NUM  (FN),
    .SWITCH_TIME(ST),
    .DW         (DW),
    .IW         (IW)
  ) u_dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fs_pulse();
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
  endtask

  function automatic logic [31:0] pix(input int k);
    return 32'(12'h100 * k + 1);
  endfunction

  initial begin
    int pp[12];
    pp = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

    for (int k = 0; k < FN; k++) begin
      bus.dout[k*DW +: DW] = 12'(12'h100 * k + 1);
    end
    bus.frame_start = 1'b0;
    bus.mode        = 2'b00;
    bus.pause       = 1'b0;
    bus.step        = 1'b0;
    bus.restart     = 1'b0;

    cyc(2);
    chk("rst_idx", 32'(bus.frame_idx), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_tick", 32'(bus.frame_tick), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    // Loop: one advance per frame_start since each gap exceeds the hold interval.
    for (int i = 1; i <= 7; i++) begin
      cyc(24);
      fs_pulse();
      chk("loop_idx", 32'(bus.frame_idx), 32'(i % FN));
      chk("loop_tick", 32'(bus.frame_tick), 1);
      cyc(1);
      chk("loop_tick_off", 32'(bus.frame_tick), 0);
      chk("loop_rdata", 32'(bus.rdata), pix(i % FN));
    end

    bus.mode = 2'b01;
    do_restart();
    chk("rs_idx", 32'(bus.frame_idx), 0);
    chk("rs_tick", 32'(bus.frame_tick), 0);
    for (int i = 0; i < 12; i++) begin
      cyc(24);
      fs_pulse();
      chk("ping_idx", 32'(bus.frame_idx), 32'(pp[i]));
      chk("ping_tick", 32'(bus.frame_tick), 1);
    end

    // Leaving ping-pong for loop keeps the current index.
    bus.mode = 2'b00;
    cyc(24);
    fs_pulse();
    chk("p2l_idx", 32'(bus.frame_idx), 3);

    bus.mode = 2'b10;
    do_restart();
    chk("os_start_idx", 32'(bus.frame_idx), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(24);
      fs_pulse();
      chk("os_idx", 32'(bus.frame_idx), 32'(i));
      chk("os_done", 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(24);
      fs_pulse();
      chk("os_hold_idx", 32'(bus.frame_idx), 5);
      chk("os_hold_tick", 32'(bus.frame_tick), 0);
      chk("os_hold_done", 32'(bus.done), 1);
    end
    do_restart();
    chk("os_rs_idx", 32'(bus.frame_idx), 0);
    chk("os_rs_done", 32'(bus.done), 0);

    // Paused: three steps collapse into a single advance.
    bus.mode  = 2'b00;
    bus.pause = 1'b1;
    do_restart();
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      cyc(1);
      bus.step = 1'b0;
      cyc(2);
    end
    fs_pulse();
    chk("step_idx", 32'(bus.frame_idx), 1);
    chk("step_tick", 32'(bus.frame_tick), 1);
    cyc(5);
    fs_pulse();
    chk("step_once", 32'(bus.frame_idx), 1);
    bus.pause = 1'b0;
    bus.step  = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    cyc(2);
    fs_pulse();
    chk("step_unpaused", 32'(bus.frame_idx), 1);

    cyc(100);
    chk("expire_no_fs", 32'(bus.frame_idx), 1);
    fs_pulse();
    chk("expire_single", 32'(bus.frame_idx), 2);
    cyc(1);
    chk("expire_tick_off", 32'(bus.frame_tick), 0);

    cyc(24);
    fs_pulse();
    chk("pre_rst_idx", 32'(bus.frame_idx), 3);
    cyc(24);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_idx", 32'(bus.frame_idx), 0);
    chk("mid_rst_rdata", 32'(bus.rdata), 0);
    chk("mid_rst_tick", 32'(bus.frame_tick), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    fs_pulse();
    chk("post_rst_noadv", 32'(bus.frame_idx), 0);
    chk("post_rst_notick", 32'(bus.frame_tick), 0);

    bus.mode = 2'b11;
    cyc(40);
    fs_pulse();
    chk("hold_idx", 32'(bus.frame_idx), 0);
    bus.mode = 2'b00;
    fs_pulse();
    chk("hold_cleared", 32'(bus.frame_idx), 0);
    cyc(1);
    chk("hold_rdata", 32'(bus.rdata), pix(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
